// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync_fifo slice.
// Read-mode selector and count-width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  function automatic int fifo_cnt_w(
    input int depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH simple dual-port RAM.
// Synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: count, almost flags, flush,
// sticky errors, standard or FWFT read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH     = 16,
  parameter int         AF_THRESH = DEPTH * 3 / 4,
  parameter int         AE_THRESH = DEPTH / 4,
  parameter fifo_mode_e MODE      = FIFO_STD,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = fifo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] rd_q;
  logic             rv_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
      unique case (1'b1)
        wr_ok && !rd_ok: count <= count + 1'b1;
        rd_ok && !wr_ok: count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else if (flush) begin
      rv_q <= 1'b0;
    end else begin
      rv_q <= rd_ok;
      if (rd_ok) rd_q <= mem_rdata;
    end
  end

  always_comb begin
    rd_data  = rd_q;
    rd_valid = rv_q;
    if (MODE == FIFO_FWFT) begin
      rd_data  = empty ? '0 : mem_rdata;
      rd_valid = !empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo.
// Drives a STD and a FWFT instance in lockstep.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;

  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [4:0]   count;
  logic         full, empty, almost_full, almost_empty;
  logic         overflow, underflow;

  logic [W-1:0] f_rd_data;
  logic         f_rd_valid;
  logic [4:0]   f_count;
  logic         f_full, f_empty, f_af, f_ae;
  logic         f_ovf, f_udf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] expq[$];
  logic [W-1:0] last_rd = '0;
  bit           m_ovf = 0;
  bit           m_udf = 0;

  sync_fifo #(
    .WIDTH(W), .DEPTH(D),
    .AF_THRESH(AF), .AE_THRESH(AE),
    .MODE(FIFO_STD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(
    .WIDTH(W), .DEPTH(D),
    .AF_THRESH(AF), .AE_THRESH(AE),
    .MODE(FIFO_FWFT)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string      name,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL std_valid: got 1 want 0 at %0t",
                   $time);
        end else begin
          logic [W-1:0] e;
          e = expq.pop_front();
          chk("std_rd_data", rd_data, e);
          last_rd = e;
        end
      end else begin
        chk("std_rd_hold", rd_data, last_rd);
      end
    end
  end

  task automatic check_state();
    int n;
    logic [W-1:0] head;
    n = mq.size();
    head = (n != 0) ? mq[0] : '0;
    chk("count", count, n);
    chk("full", full, n == D);
    chk("empty", empty, n == 0);
    chk("almost_full", almost_full, n >= AF);
    chk("almost_empty", almost_empty, n <= AE);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
    chk("f_count", f_count, n);
    chk("f_ovf", f_ovf, m_ovf);
    chk("f_udf", f_udf, m_udf);
    chk("f_rd_valid", f_rd_valid, n != 0);
    chk("f_rd_data", f_rd_data, head);
  endtask

  task automatic cyc(
    input bit         w,
    input logic [W-1:0] d,
    input bit         r,
    input bit         f
  );
    int n;
    bit wa, ra;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    n  = mq.size();
    wa = w && (n < D) && !f;
    ra = r && (n > 0) && !f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (w && n == D) m_ovf = 1;
      if (r && n == 0) m_udf = 1;
      if (ra) expq.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    #1;
    wr_en = 0;
    rd_en = 0;
    flush = 0;
    check_state();
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    m_ovf   = 0;
    m_udf   = 0;
    last_rd = '0;
  endtask

  task automatic drain();
    while (mq.size() != 0) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    chk("exp_drained", expq.size(), 0);
  endtask

  initial begin
    rst_n   = 0;
    flush   = 0;
    wr_en   = 0;
    rd_en   = 0;
    wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 1; i <= 16; i++) cyc(1, W'(i), 0, 0);
    drain();

    for (int i = 0; i < 16; i++) cyc(1, $urandom, 0, 0);
    cyc(1, 32'hDEAD, 0, 0);
    cyc(1, 32'hDEAD, 1, 0);
    drain();
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    cyc(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, $urandom, 1, 0);
    drain();
    cyc(1, 32'hC0DE, 1, 0);
    drain();

    cyc(1, 32'hA5A5, 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    for (int i = 0; i < 17; i++) cyc(1, $urandom, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 0);
    cyc(1, 32'h77, 1, 1);
    cyc(1, 32'h55, 0, 0);
    drain();

    for (int p = 0; p < 3; p++) begin
      int pw;
      pw = (p == 0) ? 75 : (p == 1) ? 25 : 50;
      for (int i = 0; i < 150; i++) begin
        cyc($urandom_range(0, 99) < pw, $urandom,
            $urandom_range(0, 99) < 100 - pw + 10,
            $urandom_range(0, 63) == 0);
      end
    end
    drain();

    cyc(0, '0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0);
    #3 rst_n = 0;
    model_reset();
    #1;
    check_state();
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_rd_data", rd_data, 0);
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    cyc(1, 32'h1234_5678, 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    chk("post_rst_last", last_rd, 32'h1234_5678);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
